// File: rtl/ofdm_tx_pkg.sv
// Shared definitions for the OFDM transmit frame path: sample and symbol
// counter widths, output sample type codes, frame geometry and the
// scheduler state encoding.
package ofdm_tx_pkg;

  localparam int SAMPLE_W  = 16;  // {I[15:8], Q[7:0]}
  localparam int SYM_CNT_W = 8;   // DATA symbol count width

  // Frame geometry in samples.  The scheduler itself trusts the sources'
  // last flags; these sizes describe what a well-behaved source delivers.
  localparam int PREAMBLE_LEN = 320;  // STS + LTS
  localparam int SYM_LEN      = 80;   // one OFDM symbol incl. cyclic prefix

  // Tag carried alongside every output sample.
  localparam logic [1:0] TYPE_TRAIN = 2'd0;
  localparam logic [1:0] TYPE_SIG   = 2'd1;
  localparam logic [1:0] TYPE_DATA  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TRAIN = 3'd1,
    ST_SIG   = 3'd2,
    ST_DATA  = 3'd3,
    ST_GAP   = 3'd4
  } sched_state_t;

  // Type tag a given state stamps on the samples it forwards.
  function automatic logic [1:0] state_type(sched_state_t s);
    logic [1:0] t;
    t = TYPE_TRAIN;
    if (s == ST_SIG)  t = TYPE_SIG;
    if (s == ST_DATA) t = TYPE_DATA;
    return t;
  endfunction

endpackage

// File: rtl/ofdm_frame_sched_if.sv
// Signal bundle between the frame scheduler and its environment: frame
// control, the three sample sources and the single output stream.
//
// Handshake rule for every stream (train_*, sig_*, data_*, m_*): a sample
// moves on a rising clock edge where valid and ready are both high.  The
// producer holds data/last stable while valid is high and ready is low.
// Ready never depends combinationally on the same stream's valid.
interface ofdm_frame_sched_if #(
  parameter int DW    = 16,
  parameter int SYM_W = 8
);

  // frame control
  logic             start;
  logic [SYM_W-1:0] num_sym;
  logic             abort;
  logic             busy;
  logic             done;

  // training source
  logic [DW-1:0]    train_din;
  logic             train_vld;
  logic             train_last;
  logic             train_rdy;

  // SIGNAL symbol source
  logic [DW-1:0]    sig_din;
  logic             sig_vld;
  logic             sig_last;
  logic             sig_rdy;

  // DATA symbol source
  logic [DW-1:0]    data_din;
  logic             data_vld;
  logic             data_last;
  logic             data_rdy;

  // output stream towards IFFT/DAC
  logic [DW-1:0]    m_dout;
  logic             m_vld;
  logic             m_last;
  logic [1:0]       m_type;
  logic [SYM_W-1:0] m_sym;
  logic             m_rdy;

  // scheduler side
  modport master (
    input  start, num_sym, abort,
    output busy, done,
    input  train_din, train_vld, train_last,
    output train_rdy,
    input  sig_din, sig_vld, sig_last,
    output sig_rdy,
    input  data_din, data_vld, data_last,
    output data_rdy,
    output m_dout, m_vld, m_last, m_type, m_sym,
    input  m_rdy
  );

  // environment side (sources, sink, controller)
  modport slave (
    output start, num_sym, abort,
    input  busy, done,
    output train_din, train_vld, train_last,
    input  train_rdy,
    output sig_din, sig_vld, sig_last,
    input  sig_rdy,
    output data_din, data_vld, data_last,
    input  data_rdy,
    input  m_dout, m_vld, m_last, m_type, m_sym,
    output m_rdy
  );

endinterface

// File: rtl/ofdm_out_reg.sv
// Single-entry registered stream stage (data + last + user tag).
// The caller decides when to load; can_load tells it the stage is empty or
// is being drained this cycle, which gives one sample per cycle with no
// bubble while the sink keeps ready high.
module ofdm_out_reg #(
  parameter int DW = 16,
  parameter int UW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic [UW-1:0] in_user,
  output logic [DW-1:0] out_data,
  output logic          out_vld,
  output logic          out_last,
  output logic [UW-1:0] out_user,
  input  logic          out_rdy,
  output logic          can_load
);

  assign can_load = !out_vld || out_rdy;

  // Holding register: load wins over drain, clear wins over both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_user <= '0;
    end else if (clr) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end else if (load) begin
      out_data <= in_data;
      out_vld  <= 1'b1;
      out_last <= in_last;
      out_user <= in_user;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/ofdm_frame_sched.sv
// Frame-level TX scheduler: per accepted start it forwards the training
// preamble, the SIGNAL symbol and num_sym DATA symbols onto one output
// stream, tags every sample with its type and DATA symbol number, then
// holds off new frames for GAP_LEN idle cycles.
module ofdm_frame_sched
  import ofdm_tx_pkg::*;
#(
  parameter int DW      = SAMPLE_W,
  parameter int SYM_W   = SYM_CNT_W,
  parameter int GAP_LEN = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ofdm_frame_sched_if.master bus,
  output sched_state_t       dbg_state
);

  localparam int UW = 2 + SYM_W;
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);
  // Where a frame goes after its final sample has been taken from a source.
  localparam sched_state_t END_ST = (GAP_LEN == 0) ? ST_IDLE : ST_GAP;

  sched_state_t     state, state_nxt;
  logic [SYM_W-1:0] sym_cnt;
  logic [SYM_W-1:0] num_sym_q;
  logic [GW-1:0]    gap_cnt;

  logic             can_load;
  logic             start_ok;
  logic             train_xfer, sig_xfer, data_xfer;
  logic             last_sym;

  logic             ld;
  logic [DW-1:0]    ld_data;
  logic             ld_last;
  logic [1:0]       ld_type;
  logic [SYM_W-1:0] ld_sym;

  logic [DW-1:0]    out_data;
  logic             out_vld;
  logic             out_last;
  logic [UW-1:0]    out_user;

  // Source grants come only from registered state and the output stage
  // occupancy, so no source valid can loop back into its own ready.
  assign bus.train_rdy = (state == ST_TRAIN) && can_load;
  assign bus.sig_rdy   = (state == ST_SIG)   && can_load;
  assign bus.data_rdy  = (state == ST_DATA)  && can_load;

  assign train_xfer = bus.train_vld && bus.train_rdy;
  assign sig_xfer   = bus.sig_vld   && bus.sig_rdy;
  assign data_xfer  = bus.data_vld  && bus.data_rdy;

  assign start_ok = (state == ST_IDLE) && bus.start && !bus.abort;
  assign last_sym = (sym_cnt == (num_sym_q - SYM_W'(1)));

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_TRAIN;
      ST_TRAIN: if (train_xfer && bus.train_last) state_nxt = ST_SIG;
      ST_SIG:   if (sig_xfer && bus.sig_last)
                  state_nxt = (num_sym_q == '0) ? END_ST : ST_DATA;
      ST_DATA:  if (data_xfer && bus.data_last && last_sym) state_nxt = END_ST;
      ST_GAP:   if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (bus.abort) state_nxt = ST_IDLE;
  end

  // Source mux into the output stage, with the frame-last flag and tags.
  always_comb begin
    ld      = 1'b0;
    ld_data = '0;
    ld_last = 1'b0;
    ld_type = state_type(state);
    ld_sym  = '0;
    case (state)
      ST_TRAIN: begin
        ld      = train_xfer;
        ld_data = bus.train_din;
      end
      ST_SIG: begin
        ld      = sig_xfer;
        ld_data = bus.sig_din;
        ld_last = bus.sig_last && (num_sym_q == '0);
      end
      ST_DATA: begin
        ld      = data_xfer;
        ld_data = bus.data_din;
        ld_last = bus.data_last && last_sym;
        ld_sym  = sym_cnt;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Frame length is captured once so later changes on num_sym are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        num_sym_q <= '0;
    else if (start_ok) num_sym_q <= bus.num_sym;
  end

  // DATA symbol counter: advances after the last sample of each symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            sym_cnt <= '0;
    else if (bus.abort || start_ok)        sym_cnt <= '0;
    else if (data_xfer && bus.data_last)   sym_cnt <= sym_cnt + SYM_W'(1);
  end

  // Inter-frame gap counter, only running while in GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               gap_cnt <= '0;
    else if (state != ST_GAP) gap_cnt <= '0;
    else                      gap_cnt <= gap_cnt + GW'(1);
  end

  ofdm_out_reg #(
    .DW (DW),
    .UW (UW)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.abort),
    .load     (ld),
    .in_data  (ld_data),
    .in_last  (ld_last),
    .in_user  ({ld_type, ld_sym}),
    .out_data (out_data),
    .out_vld  (out_vld),
    .out_last (out_last),
    .out_user (out_user),
    .out_rdy  (bus.m_rdy),
    .can_load (can_load)
  );

  assign bus.m_dout = out_data;
  assign bus.m_vld  = out_vld;
  assign bus.m_last = out_last;
  assign bus.m_type = out_user[UW-1 -: 2];
  assign bus.m_sym  = out_user[SYM_W-1:0];

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = out_vld && bus.m_rdy && out_last;
  assign dbg_state = state;

endmodule
